// File: rtl/hazard_stall_unit_pkg.sv
// hazard_stall_unit_pkg: hazard FSM states, timeout default, opcode constants and source-usage decode.
package hazard_stall_unit_pkg;
    typedef enum logic {RUN, MEM_WAIT} hazard_state_e;
    localparam int HAZ_MEM_TIMEOUT_DEFAULT = 255;
    localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
    localparam logic [6:0] OPCODE_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
    localparam logic [6:0] OPCODE_JALR   = 7'b1100111;

    function automatic logic uses_rs1(input logic [6:0] op);
        return op inside {OPCODE_OP, OPCODE_OPIMM, OPCODE_LOAD, OPCODE_STORE, OPCODE_BRANCH, OPCODE_JALR};
    endfunction

    function automatic logic uses_rs2(input logic [6:0] op);
        return op inside {OPCODE_OP, OPCODE_STORE, OPCODE_BRANCH};
    endfunction
endpackage

// File: rtl/hazard_stall_unit_src_match.sv
// hazard_src_match: load-use hit from the ID instruction's real source operands against a load in EX.
module hazard_src_match
    import hazard_stall_unit_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [4:0] rs1,
    input  logic [4:0] rs2,
    input  logic       ex_is_load,
    input  logic [4:0] ex_dest,
    output logic       lu_hit
);
    assign lu_hit = ex_is_load && ex_dest != 5'd0 &&
                    ((uses_rs1(opcode) && rs1 == ex_dest) || (uses_rs2(opcode) && rs2 == ex_dest));
endmodule

// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit: load-use stall, taken-branch flush and data-memory wait/timeout interlock.
// Optional saturating perf counters are built only when HAZARD_PERF_CNT_EN is defined.
module hazard_stall_unit
    import hazard_stall_unit_pkg::*;
#(
    parameter int MEM_TIMEOUT = HAZ_MEM_TIMEOUT_DEFAULT,
    parameter int CNT_W       = 32
)(
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       id_instr_opcode_ip,
    input  logic [4:0]       ID_rs1_ip,
    input  logic [4:0]       ID_rs2_ip,
    input  logic             ID_EX_is_load_ip,
    input  logic [4:0]       ID_EX_dest_ip,
    input  logic             ex_branch_taken_ip,
    input  logic             dmem_req_ip,
    input  logic             dmem_rvalid_ip,
    output logic             pc_stall_op,
    output logic             if_id_stall_op,
    output logic             if_id_flush_op,
    output logic             id_ex_bubble_op,
    output logic             ex_mem_stall_op,
    output logic             mem_timeout_op,
    output logic [CNT_W-1:0] stall_cycles_op,
    output logic [CNT_W-1:0] flush_count_op
);
    hazard_state_e state;
    logic [15:0]   wait_cnt;
    logic          lu_hit, mem_miss, wait_exp, run, hold, flush, lu_stall;

    hazard_src_match u_match (
        .opcode     (id_instr_opcode_ip),
        .rs1        (ID_rs1_ip),
        .rs2        (ID_rs2_ip),
        .ex_is_load (ID_EX_is_load_ip),
        .ex_dest    (ID_EX_dest_ip),
        .lu_hit     (lu_hit)
    );

    // Outputs are gated by reset so they read 0 the instant reset asserts.
    always_comb begin
        mem_miss = dmem_req_ip && !dmem_rvalid_ip;
        wait_exp = wait_cnt == 16'(MEM_TIMEOUT);
        run      = reset && state == RUN;
        hold     = reset && (state == MEM_WAIT ? !dmem_rvalid_ip && !wait_exp : mem_miss);
        flush    = run && !mem_miss && ex_branch_taken_ip;
        lu_stall = run && !mem_miss && !ex_branch_taken_ip && lu_hit;
    end

    assign pc_stall_op     = hold || lu_stall;
    assign if_id_stall_op  = hold || lu_stall;
    assign if_id_flush_op  = flush;
    assign id_ex_bubble_op = flush || lu_stall;
    assign ex_mem_stall_op = hold;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= RUN;
            wait_cnt       <= '0;
            mem_timeout_op <= 1'b0;
        end else if (state == RUN) begin
            if (mem_miss) begin
                state    <= MEM_WAIT;
                wait_cnt <= 16'd1;
            end
        end else if (dmem_rvalid_ip) begin
            state <= RUN;
        end else if (wait_exp) begin
            state          <= RUN;
            mem_timeout_op <= 1'b1;
        end else begin
            wait_cnt <= wait_cnt + 16'd1;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cycles_op <= '0;
            flush_count_op  <= '0;
        end else begin
            if (pc_stall_op && !(&stall_cycles_op))
                stall_cycles_op <= stall_cycles_op + CNT_W'(1);
            if (if_id_flush_op && !(&flush_count_op))
                flush_count_op <= flush_count_op + CNT_W'(1);
        end
    end
`else
    assign stall_cycles_op = '0;
    assign flush_count_op  = '0;
`endif
endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb_hazard_stall_unit: scoreboard bench; expected control vectors queued at drive time, popped at negedge.
module tb_hazard_stall_unit;
    import hazard_stall_unit_pkg::*;
`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif
    // Expected vector order: pc_stall, if_id_stall, if_id_flush, id_ex_bubble, ex_mem_stall, mem_timeout
    localparam logic [5:0] ZERO  = 6'b000000;
    localparam logic [5:0] LU    = 6'b110100;
    localparam logic [5:0] FLUSH = 6'b001100;
    localparam logic [5:0] MEMST = 6'b110010;
    localparam logic [5:0] TO    = 6'b000001;

    logic        clk = 1'b0, reset = 1'b0;
    logic [6:0]  opcode = '0;
    logic [4:0]  rs1 = '0, rs2 = '0, dest = '0;
    logic        is_load = 1'b0, br = 1'b0, req = 1'b0, rvalid = 1'b0;
    logic        pc_stall, if_id_stall, if_id_flush, id_ex_bubble, ex_mem_stall, mem_timeout;
    logic [31:0] stall_cycles, flush_count;
    logic [5:0]  ctl, e;
    logic [5:0]  exp_q[$];
    int          checks = 0, errors = 0;
    int unsigned m_stall = 0, m_flush = 0;

    always #5 clk = ~clk;

    hazard_stall_unit #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
        .clk(clk), .reset(reset),
        .id_instr_opcode_ip(opcode), .ID_rs1_ip(rs1), .ID_rs2_ip(rs2),
        .ID_EX_is_load_ip(is_load), .ID_EX_dest_ip(dest),
        .ex_branch_taken_ip(br), .dmem_req_ip(req), .dmem_rvalid_ip(rvalid),
        .pc_stall_op(pc_stall), .if_id_stall_op(if_id_stall), .if_id_flush_op(if_id_flush),
        .id_ex_bubble_op(id_ex_bubble), .ex_mem_stall_op(ex_mem_stall), .mem_timeout_op(mem_timeout),
        .stall_cycles_op(stall_cycles), .flush_count_op(flush_count)
    );

    assign ctl = {pc_stall, if_id_stall, if_id_flush, id_ex_bubble, ex_mem_stall, mem_timeout};

    // Counters lag one edge, so compare them before folding this cycle into the model.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (ctl !== e) begin
                errors++;
                $display("FAIL ctl @%0t: got %b expected %b", $time, ctl, e);
            end
            checks++;
            if (stall_cycles !== (PERF ? m_stall : 0)) begin
                errors++;
                $display("FAIL stall_cycles @%0t: got %0d expected %0d", $time, stall_cycles, PERF ? m_stall : 0);
            end
            checks++;
            if (flush_count !== (PERF ? m_flush : 0)) begin
                errors++;
                $display("FAIL flush_count @%0t: got %0d expected %0d", $time, flush_count, PERF ? m_flush : 0);
            end
            m_stall += 32'(e[5]);
            m_flush += 32'(e[3]);
        end
    end

    task automatic drive(input logic [6:0] op, input logic [4:0] r1, input logic [4:0] r2,
                         input logic ld, input logic [4:0] dst, input logic b,
                         input logic rq, input logic rv, input logic [5:0] ev);
        @(posedge clk);
        #1;
        opcode = op; rs1 = r1; rs2 = r2; is_load = ld; dest = dst; br = b; req = rq; rvalid = rv;
        exp_q.push_back(ev);
    endtask

    task automatic test_reset;
        opcode = OPCODE_OP; rs1 = 5'd5; rs2 = 5'd7; is_load = 1'b1; dest = 5'd5;
        br = 1'b1; req = 1'b1; rvalid = 1'b0;
        #3;
        checks++;
        if (ctl !== ZERO) begin errors++; $display("FAIL reset_ctl: got %b expected %b", ctl, ZERO); end
        checks++;
        if (stall_cycles !== 0) begin errors++; $display("FAIL reset_stall_cnt: got %0d expected 0", stall_cycles); end
        checks++;
        if (flush_count !== 0) begin errors++; $display("FAIL reset_flush_cnt: got %0d expected 0", flush_count); end
        #9;
        is_load = 1'b0; br = 1'b0; req = 1'b0;
        reset = 1'b1;
        #1;
        checks++;
        if (ctl !== ZERO) begin errors++; $display("FAIL reset_release: got %b expected %b", ctl, ZERO); end
    endtask

    task automatic test_load_use;
        drive(OPCODE_OP,     5, 7, 1, 5, 0, 0, 0, LU);
        drive(OPCODE_OP,     5, 7, 0, 0, 0, 0, 0, ZERO);
        drive(OPCODE_STORE,  1, 9, 1, 9, 0, 0, 0, LU);
        drive(OPCODE_BRANCH, 3, 4, 1, 4, 0, 0, 0, LU);
        drive(OPCODE_JALR,   8, 2, 1, 8, 0, 0, 0, LU);
        drive(OPCODE_LOAD,  12, 0, 1, 12, 0, 0, 0, LU);
        drive(OPCODE_OP,     0, 0, 1, 0, 0, 0, 0, ZERO);
        drive(OPCODE_OPIMM,  1, 6, 1, 6, 0, 0, 0, ZERO);
        drive(OPCODE_JALR,   1, 6, 1, 6, 0, 0, 0, ZERO);
        drive(OPCODE_LUI,    6, 6, 1, 6, 0, 0, 0, ZERO);
        drive(OPCODE_OP,     5, 5, 0, 5, 0, 0, 0, ZERO);
        drive(OPCODE_OP,     5, 5, 0, 0, 0, 1, 1, ZERO);
        @(negedge clk);
    endtask

    task automatic test_branch;
        logic [31:0] f0;
        drive(OPCODE_OP, 5, 7, 1, 5, 1, 0, 0, FLUSH);
        f0 = flush_count;
        drive(OPCODE_OP, 5, 7, 0, 0, 0, 0, 0, ZERO);
        @(negedge clk);
        checks++;
        if (flush_count - f0 !== (PERF ? 32'd1 : 32'd0)) begin
            errors++;
            $display("FAIL branch_flush_delta: got %0d expected %0d", flush_count - f0, PERF ? 1 : 0);
        end
    endtask

    task automatic test_mem_wait;
        logic [31:0] s0;
        drive(OPCODE_OP, 0, 0, 0, 0, 0, 1, 0, MEMST);
        s0 = stall_cycles;
        drive(OPCODE_OP, 0, 0, 0, 0, 0, 1, 0, MEMST);
        drive(OPCODE_OP, 5, 7, 1, 5, 1, 1, 0, MEMST);
        drive(OPCODE_OP, 0, 0, 0, 0, 0, 1, 1, ZERO);
        @(negedge clk);
        checks++;
        if (stall_cycles - s0 !== (PERF ? 32'd3 : 32'd0)) begin
            errors++;
            $display("FAIL mem_stall_delta: got %0d expected %0d", stall_cycles - s0, PERF ? 3 : 0);
        end
        drive(OPCODE_OP, 0, 0, 0, 0, 0, 0, 0, ZERO);
    endtask

    task automatic test_timeout;
        drive(OPCODE_OP, 0, 0, 0, 0, 0, 1, 0, MEMST);
        repeat (3) drive(OPCODE_OP, 0, 0, 0, 0, 0, 1, 0, MEMST);
        drive(OPCODE_OP, 0, 0, 0, 0, 0, 1, 0, ZERO);
        drive(OPCODE_OP, 0, 0, 0, 0, 0, 0, 0, TO);
        drive(OPCODE_OP, 5, 7, 1, 5, 0, 0, 0, LU | TO);
        drive(OPCODE_OP, 0, 0, 0, 0, 0, 0, 0, TO);
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        drive(OPCODE_OP, 0, 0, 0, 0, 0, 1, 0, MEMST | TO);
        drive(OPCODE_OP, 0, 0, 0, 0, 0, 0, 1, TO);
        drive(OPCODE_OP, 5, 7, 1, 5, 1, 0, 0, FLUSH | TO);
        drive(OPCODE_OP, 0, 0, 0, 0, 0, 1, 1, TO);
        @(negedge clk);
    endtask

    task automatic test_async_reset;
        drive(OPCODE_OP, 0, 0, 0, 0, 0, 1, 0, MEMST | TO);
        drive(OPCODE_OP, 0, 0, 0, 0, 0, 1, 0, MEMST | TO);
        @(negedge clk);
        #2;
        reset = 1'b0;
        m_stall = 0;
        m_flush = 0;
        #1;
        checks++;
        if (ctl !== ZERO) begin errors++; $display("FAIL async_reset_ctl: got %b expected %b", ctl, ZERO); end
        checks++;
        if (stall_cycles !== 0) begin errors++; $display("FAIL async_reset_stall_cnt: got %0d expected 0", stall_cycles); end
        checks++;
        if (flush_count !== 0) begin errors++; $display("FAIL async_reset_flush_cnt: got %0d expected 0", flush_count); end
        @(posedge clk);
        #2;
        req = 1'b0;
        reset = 1'b1;
        drive(OPCODE_OP, 5, 7, 1, 5, 0, 0, 0, LU);
        drive(OPCODE_OP, 0, 0, 0, 0, 0, 0, 0, ZERO);
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_timeout();
        test_back_to_back();
        test_async_reset();
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
- Pipeline interlock controller for the 5-stage RISC-V core; the counterpart of the forwarding controller.
- Forwarding resolves the hazards it can. This block owns the cases forwarding cannot cover:
  - load-use stall and bubble,
  - taken-branch flush,
  - multi-cycle data-memory wait with timeout.
- Drives the stall, flush and bubble controls of the PC, IF/ID, ID/EX and EX/MEM registers.

Parameters:
- MEM_TIMEOUT, 255: maximum MEM_WAIT cycles before abort; legal range 1..65535.
- CNT_W, 32: width of the performance counters.

Ports:
- clk  input  1  core clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- id_instr_opcode_ip  input  7  opcode of the instruction in ID.
- ID_rs1_ip  input  5  rs1 of the instruction in ID.
- ID_rs2_ip  input  5  rs2 of the instruction in ID.
- ID_EX_is_load_ip  input  1  the instruction in EX is a load.
- ID_EX_dest_ip  input  5  rd of the instruction in EX.
- ex_branch_taken_ip  input  1  branch/jump in EX redirects the PC this cycle.
- dmem_req_ip  input  1  the MEM stage has an outstanding data-memory access.
- dmem_rvalid_ip  input  1  data memory completes the access this cycle.
- pc_stall_op  output  1  hold PC.
- if_id_stall_op  output  1  hold IF/ID.
- if_id_flush_op  output  1  load NOP into IF/ID.
- id_ex_bubble_op  output  1  load bubble into ID/EX (wb = NO_WRITEBACK).
- ex_mem_stall_op  output  1  hold EX/MEM and MEM/WB.
- mem_timeout_op  output  1  sticky memory-timeout error.
- stall_cycles_op  output  CNT_W  count of stall cycles.
- flush_count_op  output  CNT_W  count of taken-branch flushes.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=RUN, wait counter=0, mem_timeout_op=0, both perf counters=0.
  - All control outputs are combinational from state and inputs, and are 0 while in reset.
- States are encoded as hazard_state_e: RUN, MEM_WAIT.
- Load-use detect (combinational), lu_hit:
  - Requires ID_EX_is_load_ip=1, ID_EX_dest_ip!=0, and a source match.
  - rs1 match applies to OPCODE_OP, OPIMM, LOAD, STORE, BRANCH and JALR.
  - rs2 match applies to OP, STORE and BRANCH only.
  - All other opcodes never hit.
- RUN state, priority highest first:
  1. dmem_req_ip=1 and dmem_rvalid_ip=0:
     - assert pc_stall_op, if_id_stall_op, ex_mem_stall_op and id_ex_bubble_op=0 (freeze all stages);
     - next state=MEM_WAIT, counter=1.
  2. ex_branch_taken_ip=1:
     - assert if_id_flush_op and id_ex_bubble_op; no stall;
     - stay in RUN. A lu_hit in the same cycle is ignored, because the dependent instruction is flushed.
  3. lu_hit:
     - assert pc_stall_op, if_id_stall_op and id_ex_bubble_op for exactly one cycle; stay in RUN;
     - the next cycle has no re-hit, because ID/EX then holds a bubble with is_load=0.
  4. Otherwise all control outputs are 0.
- MEM_WAIT state:
  - pc_stall_op, if_id_stall_op and ex_mem_stall_op stay asserted; id_ex_bubble_op=0.
  - Branch and load-use inputs are ignored, since the stages are frozen and re-evaluated on return.
  - On dmem_rvalid_ip=1: deassert all stalls in that same cycle and go to RUN.
  - Else if counter==MEM_TIMEOUT: set mem_timeout_op=1 (sticky until reset), deassert stalls and go to RUN.
  - Else counter increments.
- dmem_req_ip and dmem_rvalid_ip both high in RUN is a zero-wait access: no stall.
- Reset asserted mid-MEM_WAIT returns to RUN immediately and clears everything.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- When defined:
  - stall_cycles_op increments on every cycle with pc_stall_op=1.
  - flush_count_op increments on every cycle with if_id_flush_op=1.
  - Both counters saturate at all-ones.
- When undefined: both ports are driven constant 0 and no counter flops are built.

Decomposition:
- CORE_PKG gains the hazard_state_e typedef (RUN, MEM_WAIT) and the constant HAZ_MEM_TIMEOUT_DEFAULT=255.
- Opcode constants come from CORE_PKG.
- One sub-module, hazard_src_match: combinational opcode-based rs1/rs2 usage decode plus lu_hit. The forwarding controller can reuse it.

Test Plan:
- Load-use on rs1: ID_EX load rd=5, ID OPCODE_OP rs1=5 rs2=7 -> one cycle of pc_stall=if_id_stall=id_ex_bubble=1, then 0.
- Load-use on x0 or non-user: ID_EX load rd=0, ID rs1=0 -> no stall. ID_EX load rd=6, ID OPIMM rs2=6 -> no stall, because rs2 is unused.
- Branch beats load-use: ex_branch_taken=1 with lu_hit=1 -> if_id_flush=1, id_ex_bubble=1, pc_stall=0; flush_count increments to 1.
- Memory wait: dmem_req=1, rvalid low for 3 cycles then high -> ex_mem_stall high for 3 cycles, low on the rvalid cycle; stall_cycles=3.
- Timeout: MEM_TIMEOUT=4, rvalid never asserts -> mem_timeout_op rises after 4 MEM_WAIT cycles, state returns to RUN, flag stays 1.
- Async reset mid-MEM_WAIT: drop reset between clock edges -> all outputs 0 immediately, counters 0, state RUN.
